// File: rtl/shazam_pkg.sv
// Shared constants and types for the shazam peak-frequency SPI link.
// The transmitter and the receiver both import this package.
package shazam_pkg;

    localparam int FREQ_WIDTH     = 9;
    localparam int MAXIMAS_COUNT  = 10;
    localparam int INDEX_WIDTH    = $clog2(MAXIMAS_COUNT);
    localparam int BIT_CNT_WIDTH  = $clog2(FREQ_WIDTH);
    localparam int WORD_CNT_WIDTH = $clog2(MAXIMAS_COUNT + 1);

    typedef logic [FREQ_WIDTH-1:0] freq_t;

    // One FIFO entry: the word and its position inside the frame.
    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        freq_t                  data;
    } rx_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        WAIT_CS = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head, so a write becomes visible one clock later.
// Extended pointers give exact full/empty; a push is accepted when full only if a pop happens too.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_nxt;
    logic             head_valid;
    logic             head_valid_nxt;
    logic             push;
    logic             pop;

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = !head_valid;
    assign pop        = rd_en && head_valid;
    assign push       = wr_en && (!full || pop);
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

    // Compared against the pre-write pointer so a fresh entry shows up one clock after its write.
    assign head_valid_nxt = (wr_ptr != rd_ptr_nxt);

    // NOTE: the storage array has no reset; only pointers and the head register need a known state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr     <= rd_ptr_nxt;
            head_valid <= head_valid_nxt;
            rd_data    <= head_valid_nxt ? mem[rd_ptr_nxt[AW-1:0]] : '0;
        end
    end

endmodule

// File: rtl/maxima_spi_receiver.sv
// SPI target that deserializes frames of MAXIMAS_COUNT peak-frequency words (MSB first)
// and presents them, tagged with their frame index, as a valid/ready stream.
module maxima_spi_receiver
    import shazam_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sclk,
    input  logic                   cs,
    input  logic                   mosi,
    output freq_t                  word_data,
    output logic [INDEX_WIDTH-1:0] word_index,
    output logic                   word_last,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic                   overflow
);

    localparam logic [BIT_CNT_WIDTH-1:0]  BIT_LAST   = BIT_CNT_WIDTH'(FREQ_WIDTH - 1);
    localparam logic [WORD_CNT_WIDTH-1:0] WORD_LAST  = WORD_CNT_WIDTH'(MAXIMAS_COUNT - 1);
    localparam logic [WORD_CNT_WIDTH-1:0] WORD_FULL  = WORD_CNT_WIDTH'(MAXIMAS_COUNT);
    localparam logic [INDEX_WIDTH-1:0]    LAST_INDEX = INDEX_WIDTH'(MAXIMAS_COUNT - 1);

    // Synchronizers: [0] metastable, [1] synced, [2] history for edge detection.
    logic [2:0] sclk_pipe;
    logic [2:0] cs_pipe;
    logic [1:0] mosi_pipe;

    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;
    logic sample;

    rx_state_t state_q;
    rx_state_t state_nxt;

    logic                      start_frame;
    logic                      shift_en;
    logic                      word_done;
    logic                      last_word;
    logic                      err_short;
    logic                      err_long;

    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic [WORD_CNT_WIDTH-1:0] word_cnt;
    logic [FREQ_WIDTH-2:0]     shift_reg;
    logic                      extra_seen;
    logic                      push_q;
    rx_word_t                  push_word;
    rx_word_t                  head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_pipe <= '0;
            cs_pipe   <= '0;
            mosi_pipe <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[1:0], sclk};
            cs_pipe   <= {cs_pipe[1:0], cs};
            mosi_pipe <= {mosi_pipe[0], mosi};
        end
    end

    assign sclk_fall = !sclk_pipe[1] && sclk_pipe[2];
    assign cs_fall   = !cs_pipe[1] && cs_pipe[2];
    assign cs_rise   = cs_pipe[1] && !cs_pipe[2];
    assign sample    = sclk_fall && !cs_pipe[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // NOTE: defaulting every comb output first keeps these blocks free of inferred latches.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_nxt = RECEIVE;
            RECEIVE: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                end else if (sample && bit_cnt == BIT_LAST && word_cnt == WORD_LAST) begin
                    state_nxt = WAIT_CS;
                end
            end
            WAIT_CS: if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_frame = (state_q == IDLE) && cs_fall;
        shift_en    = (state_q == RECEIVE) && sample;
        word_done   = shift_en && (bit_cnt == BIT_LAST);
        last_word   = word_done && (word_cnt == WORD_LAST);
        err_short   = (state_q == RECEIVE) && cs_rise && (word_cnt != WORD_FULL || bit_cnt != '0);
        err_long    = (state_q == WAIT_CS) && sample && !extra_seen;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shift_reg  <= '0;
            extra_seen <= 1'b0;
            push_q     <= 1'b0;
            push_word  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            push_q     <= word_done;
            frame_done <= last_word;
            frame_err  <= err_short || err_long;

            if (word_done) begin
                push_word <= '{index: word_cnt[INDEX_WIDTH-1:0], data: {shift_reg, mosi_pipe[1]}};
            end

            if (start_frame) begin
                bit_cnt    <= '0;
                word_cnt   <= '0;
                extra_seen <= 1'b0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[FREQ_WIDTH-3:0], mosi_pipe[1]};
                if (word_done) begin
                    bit_cnt  <= '0;
                    word_cnt <= word_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (err_long) begin
                extra_seen <= 1'b1;
            end

            // A push into a full FIFO with no simultaneous pop loses the word.
            if (push_q && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH($bits(rx_word_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .wr_en  (push_q),
        .wr_data(push_word),
        .rd_en  (word_ready),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign pop        = word_valid && word_ready;
    assign word_valid = !fifo_empty;
    assign word_data  = head.data;
    assign word_index = head.index;
    assign word_last  = word_valid && (head.index == LAST_INDEX);

endmodule
